alu_regfile_datapath: RTL and testbench
=======================================

# alu_regfile_datapath

Datapath stage directly downstream of the sequencing FSMs: a 16 × 16-bit register file, two 4-bit-indexed operand muxes, an immediate select, an ALU and a processor-status flag register. Each cycle it consumes the FSM control word (`alu_op`, `muxes`, `regs_en`, `imm`), computes one result and writes it at the next rising edge into every register enabled in `regs_en`. It also drives the value shown on the board display.

## Interface
- `WIDTH`, 16: datapath and register width.
- `NREGS`, 16: register count; select fields are log2(NREGS) = 4 bits.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `alu_op`  in  8  `{op[7:4], ext[3:0]}` operation code.
- `muxes`  in  8  `[7:4]` selects A operand register, `[3:0]` selects B operand register.
- `regs_en`  in  16  per-register write enable; bit n writes Rn.
- `imm`  in  16  immediate; replaces B for immediate ops; pre-extended by the FSM.
- `result`  out  16  combinational ALU output for the current control word.
- `wb_value`  out  16  registered value of the last committed write (display source).
- `flags`  out  5  registered `{C, L, F, Z, N}`.
- `illegal`  out  1  registered sticky flag, set by an undecodable `alu_op`.

## Operation
- Operands: A = R[muxes[7:4]]; B = R[muxes[3:0]] for register ops (`op`=0), B = `imm` for all other ops.
- Register ops (`op`=0), by `ext`: 1 AND, 2 OR, 3 XOR, 5 ADD, 6 ADDU, 9 SUB, B CMP, D MOV (result = B).
- Immediate ops, by `op` (`ext` ignored): 1 ANDI, 2 ORI, 3 XORI, 5 ADDI, 6 ADDUI, 9 SUBI, B CMPI, D MOVI (result = imm), F LUI (result = {imm[7:0], 8'h00}).
- Arithmetic: 16-bit modulo wrap. SUB computes A − B.
- Flags are updated only by arithmetic and compare ops. Logic ops, MOV/MOVI and LUI hold the flags.
  - ADD/ADDI: F = signed overflow; C unchanged.
  - ADDU/ADDUI: C = carry out; F unchanged.
  - SUB/SUBI: F = signed overflow; C = borrow (A < B unsigned).
  - CMP/CMPI: Z = (A == B); L = A < B unsigned; N = A < B signed. Compare ops never write registers, whatever `regs_en` holds; `result` shows A − B.
- Writeback: every Rn with `regs_en[n]` = 1 receives `result`. Multiple bits set means broadcast write. `regs_en` = 0 means no write. When a write commits, `wb_value` takes `result`; otherwise `wb_value` holds.
- Illegal `alu_op` (unlisted code, or a control word with an X/undriven `alu_op`):
  - no register write, no flag update, `wb_value` holds;
  - `illegal` is set and stays set until reset.
- With `regs_en` = 0 the value of `alu_op` is don't-care and is never flagged illegal. This covers the FSM idle state, which drives X on `alu_op`.
- Reading and writing the same register in one cycle: reads return the old value; the new value is visible next cycle.

## Timing
- Reset (synchronous):
  - all registers R0–R15 = 0;
  - `wb_value` = 0, `flags` = 0, `illegal` = 0.
  - Reset wins over any simultaneous write.
- `result` is combinational from the current inputs and register contents: zero-cycle latency.
- Write-to-read latency: 1 cycle. A value written at edge k is readable as an operand in cycle k+1.
- `flags` and `wb_value` change at the same edge as the register write they describe.
- Reset asserted mid-sequence: all state clears at that edge. The FSM restarts from its idle state at the same edge, so the datapath and FSM stay aligned.
- No handshake. The block accepts one control word per cycle, with no stalls.

## Structure
- Shared package `datapath_pkg`:
  - `op`/`ext` opcode constants;
  - flag bit indices C/L/F/Z/N;
  - `WIDTH` and `NREGS` defaults.
- Sub-module `alu16`: purely combinational. Inputs A, B, `alu_op`. Outputs `result`, next-flag vector, flag-update-enable, write-allowed, illegal.
- The top level holds the register array, the operand muxes and the flag, `wb_value` and `illegal` registers.

## Test plan
- Fibonacci control sequence: reset, ADDI R1 = imm 1, then ADD Rn = Rn−2 + Rn−1 for n = 2..15 → R15 = 0x0262 (610), `wb_value` = 0x0262, `illegal` = 0.
- ADDI on A = 0x7FFF with imm 1 → `result` 0x8000, F = 1, C = 0. ADDU on 0xFFFF + 0x0001 → `result` 0x0000, C = 1.
- CMP with A = 5, B = 7, and `regs_en` = 0xFFFF → Z = 0, L = 1, N = 1, no register changes. CMP with A = 0xFFFF, B = 1 → L = 0, N = 1.
- Broadcast: MOVI imm 0xBEEF with `regs_en` = 0x00F0 → R4–R7 = 0xBEEF, all other registers unchanged.
- Illegal `alu_op` 0x07 with `regs_en` = 0x0002 → R1, flags and `wb_value` unchanged; `illegal` = 1 from the next cycle until reset.
- Reset asserted at step 8 of the Fibonacci run, then released → all registers 0 at the next edge, and the rerun again reaches R15 = 610.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the ALU / register-file datapath.
// Holds datapath sizes, opcode constants and flag bit positions.
// No logic beyond a small decode helper; nothing here is clocked.
package datapath_pkg;

    localparam int WIDTH  = 16;
    localparam int NREGS  = 16;
    localparam int SELW   = $clog2(NREGS);
    localparam int NFLAGS = 5;

    // Opcode field values. For register ops (op == OP_REG) the same
    // values are carried in the ext field instead.
    localparam logic [3:0] OP_REG  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ADDU = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_LUI  = 4'hF;

    // Flag vector layout {C, L, F, Z, N}
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_C = 4;

    // Any non-zero op field selects the immediate as operand B.
    function automatic logic is_imm_op(input logic [7:0] alu_op);
        return alu_op[7:4] != OP_REG;
    endfunction

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// Control word in / datapath status out bundle between sequencer and datapath.
// Ports: alu_op, muxes, regs_en, imm (to datapath); result, wb_value, flags, illegal (from datapath).
// No handshake: one control word per cycle, never stalled.
interface alu_regfile_datapath_if;
    import datapath_pkg::*;

    logic [7:0]        alu_op;
    logic [2*SELW-1:0] muxes;
    logic [NREGS-1:0]  regs_en;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  wb_value;
    logic [NFLAGS-1:0] flags;
    logic              illegal;

    modport master (
        output alu_op, muxes, regs_en, imm,
        input  result, wb_value, flags, illegal
    );

    modport slave (
        input  alu_op, muxes, regs_en, imm,
        output result, wb_value, flags, illegal
    );

endinterface

// File: rtl/alu16.sv
// Combinational ALU: decodes alu_op, computes result, candidate flags and commit qualifiers.
// Ports: a, b, alu_op in; result, next_flags, flag_upd (per-bit), write_ok, illegal out.
// Zero latency, no state, no backpressure.
module alu16
    import datapath_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [7:0]        alu_op,
    output logic [W-1:0]      result,
    output logic [NFLAGS-1:0] next_flags,
    output logic [NFLAGS-1:0] flag_upd,
    output logic              write_ok,
    output logic              illegal
);

    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] code;
    logic [W:0] sum;
    logic [W:0] diff;
    logic       ovf_add;
    logic       ovf_sub;

    assign op   = alu_op[7:4];
    assign ext  = alu_op[3:0];
    // Register and immediate ops share one code space: op for immediates,
    // ext for register ops.
    assign code = (op == OP_REG) ? ext : op;

    // The extra top bit is carry out for the sum and borrow for the difference.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    assign ovf_add = (a[W-1] == b[W-1]) && (sum[W-1]  != a[W-1]);
    assign ovf_sub = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

    always_comb begin
        result     = '0;
        next_flags = '0;
        flag_upd   = '0;
        write_ok   = 1'b1;
        illegal    = 1'b0;
        // An X/undriven code matches no item and lands in default.
        case (code)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADD: begin
                result             = sum[W-1:0];
                next_flags[FLAG_F] = ovf_add;
                flag_upd[FLAG_F]   = 1'b1;
            end
            OP_ADDU: begin
                result             = sum[W-1:0];
                next_flags[FLAG_C] = sum[W];
                flag_upd[FLAG_C]   = 1'b1;
            end
            OP_SUB: begin
                result             = diff[W-1:0];
                next_flags[FLAG_F] = ovf_sub;
                next_flags[FLAG_C] = diff[W];
                flag_upd[FLAG_F]   = 1'b1;
                flag_upd[FLAG_C]   = 1'b1;
            end
            OP_CMP: begin
                result             = diff[W-1:0];
                next_flags[FLAG_Z] = (a == b);
                next_flags[FLAG_L] = diff[W];
                next_flags[FLAG_N] = $signed(a) < $signed(b);
                flag_upd[FLAG_Z]   = 1'b1;
                flag_upd[FLAG_L]   = 1'b1;
                flag_upd[FLAG_N]   = 1'b1;
                write_ok           = 1'b0;
            end
            OP_MOV:  result = b;
            OP_LUI: begin
                // LUI exists only as an immediate op; ext = F is unassigned.
                if (op == OP_REG) begin
                    write_ok = 1'b0;
                    illegal  = 1'b1;
                end else begin
                    result = {b[W/2-1:0], {(W/2){1'b0}}};
                end
            end
            default: begin
                write_ok = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_regfile_datapath.sv
// Datapath stage: 16x16 register file, operand muxes, ALU, flag / writeback / illegal registers.
// Ports: clk, reset (sync, active-high), bus (slave: control word in, result/wb_value/flags/illegal out).
// result is combinational (0 cycles); writes visible 1 cycle later; accepts a word every cycle, never stalls.
module alu_regfile_datapath
    import datapath_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    alu_regfile_datapath_if.slave bus
);

    logic [WIDTH-1:0]  regs [NREGS];
    logic [WIDTH-1:0]  opnd_a;
    logic [WIDTH-1:0]  opnd_b;
    logic [WIDTH-1:0]  alu_result;
    logic [NFLAGS-1:0] alu_next_flags;
    logic [NFLAGS-1:0] alu_flag_upd;
    logic              alu_write_ok;
    logic              alu_illegal;

    logic              active;
    logic              commit;
    logic              do_write;
    logic [NFLAGS-1:0] flag_upd_eff;

    logic [WIDTH-1:0]  wb_q;
    logic [NFLAGS-1:0] flags_q;
    logic              illegal_q;

    assign opnd_a = regs[bus.muxes[2*SELW-1:SELW]];
    assign opnd_b = is_imm_op(bus.alu_op) ? bus.imm : regs[bus.muxes[SELW-1:0]];

    alu16 #(.W(WIDTH)) u_alu (
        .a          (opnd_a),
        .b          (opnd_b),
        .alu_op     (bus.alu_op),
        .result     (alu_result),
        .next_flags (alu_next_flags),
        .flag_upd   (alu_flag_upd),
        .write_ok   (alu_write_ok),
        .illegal    (alu_illegal)
    );

    // An all-zero enable word is the sequencer's idle cycle: alu_op is
    // meaningless then, so nothing commits and nothing is flagged.
    assign active       = |bus.regs_en;
    assign commit       = active && !alu_illegal;
    assign do_write     = commit && alu_write_ok;
    assign flag_upd_eff = commit ? alu_flag_upd : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NREGS; n++) begin
                regs[n] <= '0;
            end
            wb_q      <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            for (int n = 0; n < NREGS; n++) begin
                if (do_write && bus.regs_en[n]) begin
                    regs[n] <= alu_result;
                end
            end
            if (do_write) begin
                wb_q <= alu_result;
            end
            flags_q   <= (flags_q & ~flag_upd_eff) | (alu_next_flags & flag_upd_eff);
            illegal_q <= illegal_q || (active && alu_illegal);
        end
    end

    assign bus.result   = alu_result;
    assign bus.wb_value = wb_q;
    assign bus.flags    = flags_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Self-checking bench for alu_regfile_datapath: directed control words,
// a behavioural reference model and a per-cycle compare process.
module tb_alu_regfile_datapath;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_regfile_datapath_if bus ();

    alu_regfile_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // ---------------- reference model ----------------
    typedef enum int {K_BAD, K_AND, K_OR, K_XOR, K_ADD, K_ADDU, K_SUB, K_CMP, K_MOV, K_LUI} kind_t;

    logic [15:0] m_reg [16];
    logic [15:0] m_wb;
    bit          m_c, m_l, m_f, m_z, m_n, m_ill;

    kind_t       m_k;
    logic [15:0] m_a, m_bv, m_r;

    function automatic kind_t decode(input logic [7:0] code);
        logic [3:0] sel;
        if ($isunknown(code)) return K_BAD;
        sel = (code[7:4] == 4'h0) ? code[3:0] : code[7:4];
        case (sel)
            4'h1: return K_AND;
            4'h2: return K_OR;
            4'h3: return K_XOR;
            4'h5: return K_ADD;
            4'h6: return K_ADDU;
            4'h9: return K_SUB;
            4'hB: return K_CMP;
            4'hD: return K_MOV;
            4'hF: return (code[7:4] == 4'h0) ? K_BAD : K_LUI;
            default: return K_BAD;
        endcase
    endfunction

    function automatic int sx(input logic [15:0] v);
        int r;
        r = $signed(v);
        return r;
    endfunction

    function automatic int ux(input logic [15:0] v);
        int r;
        r = v;
        return r;
    endfunction

    function automatic bit ovf(input int s);
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic logic [15:0] model_result(input kind_t k, input logic [15:0] a, input logic [15:0] b);
        case (k)
            K_AND:         return a & b;
            K_OR:          return a | b;
            K_XOR:         return a ^ b;
            K_ADD, K_ADDU: return 16'(ux(a) + ux(b));
            K_SUB, K_CMP:  return 16'(ux(a) - ux(b));
            K_MOV:         return b;
            K_LUI:         return b * 16'd256;
            default:       return 16'h0000;
        endcase
    endfunction

    always_comb begin
        m_k  = decode(bus.alu_op);
        m_a  = m_reg[bus.muxes[7:4]];
        m_bv = (bus.alu_op[7:4] != 4'h0) ? bus.imm : m_reg[bus.muxes[3:0]];
        m_r  = model_result(m_k, m_a, m_bv);
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 16; n++) m_reg[n] <= 16'h0000;
            m_wb  <= 16'h0000;
            m_c   <= 1'b0;
            m_l   <= 1'b0;
            m_f   <= 1'b0;
            m_z   <= 1'b0;
            m_n   <= 1'b0;
            m_ill <= 1'b0;
        end else if (bus.regs_en != 16'h0000) begin
            if (m_k == K_BAD) begin
                m_ill <= 1'b1;
            end else begin
                if (m_k != K_CMP) begin
                    for (int n = 0; n < 16; n++)
                        if (bus.regs_en[n]) m_reg[n] <= m_r;
                    m_wb <= m_r;
                end
                case (m_k)
                    K_ADD:  m_f <= ovf(sx(m_a) + sx(m_bv));
                    K_ADDU: m_c <= (ux(m_a) + ux(m_bv)) > 65535;
                    K_SUB: begin
                        m_f <= ovf(sx(m_a) - sx(m_bv));
                        m_c <= ux(m_a) < ux(m_bv);
                    end
                    K_CMP: begin
                        m_z <= m_a == m_bv;
                        m_l <= ux(m_a) < ux(m_bv);
                        m_n <= sx(m_a) < sx(m_bv);
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (m_k != K_BAD) check("result", bus.result, m_r);
            check("flags",    16'(bus.flags), 16'({m_c, m_l, m_f, m_z, m_n}));
            check("wb_value", bus.wb_value, m_wb);
            check("illegal",  16'(bus.illegal), 16'(m_ill));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ctrl(input logic [7:0] op, input logic [7:0] mx, input logic [15:0] en, input logic [15:0] im);
        bus.alu_op  = op;
        bus.muxes   = mx;
        bus.regs_en = en;
        bus.imm     = im;
    endtask

    // Wait for the edge that commits the current word, then go idle.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.alu_op  = 'x;
        bus.muxes   = 8'h00;
        bus.regs_en = 16'h0000;
        bus.imm     = 16'h0000;
    endtask

    // Read Rn through a MOV with no enables and compare to a literal.
    task automatic expect_reg(input int n, input logic [15:0] val);
        set_ctrl(8'h0D, {4'h0, 4'(n)}, 16'h0000, 16'h0000);
        #2;
        check($sformatf("R%0d", n), bus.result, val);
        tick();
    endtask

    task automatic read_all();
        for (int n = 0; n < 16; n++) begin
            set_ctrl(8'h0D, {4'h0, 4'(n)}, 16'h0000, 16'h0000);
            tick();
        end
    endtask

    task automatic fib_step(input int n);
        if (n == 1) set_ctrl(8'h50, 8'h00, 16'h0002, 16'h0001);
        else        set_ctrl(8'h05, {4'(n - 2), 4'(n - 1)}, 16'(1) << n, 16'h0000);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_ctrl(8'h00, 8'h00, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_on = 1'b1;

        // Reset state
        check("rst_flags",   16'(bus.flags), 16'h0000);
        check("rst_wb",      bus.wb_value, 16'h0000);
        check("rst_illegal", 16'(bus.illegal), 16'h0000);

        // Fibonacci
        for (int n = 1; n < 16; n++) begin
            fib_step(n);
            tick();
        end
        check("model_R15", m_reg[15], 16'h0262);
        check("fib_wb",    bus.wb_value, 16'h0262);
        check("fib_ill",   16'(bus.illegal), 16'h0000);
        expect_reg(15, 16'h0262);
        expect_reg(14, 16'h0179);

        // ADDI signed overflow
        set_ctrl(8'hD0, 8'h00, 16'h0004, 16'h7FFF); tick();
        set_ctrl(8'h50, 8'h20, 16'h0008, 16'h0001);
        #2 check("addi_result", bus.result, 16'h8000);
        tick();
        check("addi_F", 16'(bus.flags[2]), 16'h0001);
        check("addi_C", 16'(bus.flags[4]), 16'h0000);

        // ADDU carry
        set_ctrl(8'hD0, 8'h00, 16'h0010, 16'hFFFF); tick();
        set_ctrl(8'hD0, 8'h00, 16'h0020, 16'h0001); tick();
        set_ctrl(8'h06, 8'h45, 16'h0040, 16'h0000);
        #2 check("addu_result", bus.result, 16'h0000);
        tick();
        check("addu_C", 16'(bus.flags[4]), 16'h0001);

        // CMP 5 vs 7 with every enable set
        set_ctrl(8'hD0, 8'h00, 16'h0100, 16'h0005); tick();
        set_ctrl(8'hD0, 8'h00, 16'h0200, 16'h0007); tick();
        set_ctrl(8'h0B, 8'h89, 16'hFFFF, 16'h0000);
        #2 check("cmp_result", bus.result, 16'hFFFE);
        tick();
        check("cmp_Z", 16'(bus.flags[1]), 16'h0000);
        check("cmp_L", 16'(bus.flags[3]), 16'h0001);
        check("cmp_N", 16'(bus.flags[0]), 16'h0001);
        check("cmp_wb", bus.wb_value, 16'h0007);
        expect_reg(8, 16'h0005);
        expect_reg(4, 16'hFFFF);
        expect_reg(15, 16'h0262);

        // CMP 0xFFFF vs 1
        set_ctrl(8'h0B, 8'h45, 16'h0001, 16'h0000); tick();
        check("cmp2_L", 16'(bus.flags[3]), 16'h0000);
        check("cmp2_N", 16'(bus.flags[0]), 16'h0001);
        expect_reg(0, 16'h0000);

        // Broadcast MOVI
        set_ctrl(8'hD0, 8'h00, 16'h00F0, 16'hBEEF); tick();
        read_all();
        expect_reg(4, 16'hBEEF);
        expect_reg(7, 16'hBEEF);
        expect_reg(3, 16'h8000);
        expect_reg(8, 16'h0005);

        // LUI
        set_ctrl(8'hF0, 8'h00, 16'h0400, 16'h12AB);
        #2 check("lui_result", bus.result, 16'hAB00);
        tick();

        // Illegal opcode
        set_ctrl(8'h07, 8'h12, 16'h0002, 16'h0000); tick();
        check("ill_set", 16'(bus.illegal), 16'h0001);
        check("ill_wb",  bus.wb_value, 16'hAB00);
        expect_reg(1, 16'h0001);
        check("ill_sticky", 16'(bus.illegal), 16'h0001);

        // Reset during step 8 of a Fibonacci rerun
        for (int n = 1; n < 8; n++) begin
            fib_step(n);
            tick();
        end
        fib_step(8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ill", 16'(bus.illegal), 16'h0000);
        check("mid_rst_wb",  bus.wb_value, 16'h0000);
        check("mid_rst_flg", 16'(bus.flags), 16'h0000);
        read_all();
        expect_reg(7, 16'h0000);
        expect_reg(15, 16'h0000);
        for (int n = 1; n < 16; n++) begin
            fib_step(n);
            tick();
        end
        expect_reg(15, 16'h0262);
        check("rerun_wb",  bus.wb_value, 16'h0262);
        check("rerun_ill", 16'(bus.illegal), 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
